// File: rtl/tomasulo_pkg.sv
// Shared definitions for the reservation-station scheduler: opcode encodings and the RS entry layout.
// The entry struct is sized from the RS_* widths below; rs_issue_sched takes its width defaults from them.
package tomasulo_pkg;

    localparam int RS_TAG_W  = 3;
    localparam int RS_DATA_W = 16;
    localparam int RS_FUNC_W = 4;

    typedef enum logic [RS_FUNC_W-1:0] {
        FUNC_ADD = 4'b0000,
        FUNC_SUB = 4'b0001,
        FUNC_MUL = 4'b0010,
        FUNC_DIV = 4'b0011,
        FUNC_LD  = 4'b0100,
        FUNC_ST  = 4'b0101,
        FUNC_BEQ = 4'b0110,
        FUNC_BNE = 4'b0111
    } func_e;

    // While an operand is pending, the low RS_TAG_W bits of v1/v2 hold the producer tag.
    typedef struct packed {
        logic                 busy;
        logic [RS_FUNC_W-1:0] func;
        logic                 q1_rdy;
        logic [RS_DATA_W-1:0] v1;
        logic                 q2_rdy;
        logic [RS_DATA_W-1:0] v2;
        logic [RS_TAG_W-1:0]  rob;
    } rs_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr, wrapping modulo DEPTH.
module rr_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         i_req,
    input  logic [$clog2(DEPTH)-1:0] i_ptr,
    output logic [DEPTH-1:0]         o_grant
);

    localparam int IDX_W = $clog2(DEPTH);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    // DEPTH is a power of two, so the index wraps naturally in IDX_W bits.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_ptr + IDX_W'(k);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_issue_sched.sv
// Reservation-station bank controller: allocation, CDB wakeup, round-robin select, registered dispatch.
// Optional macro RS_ALLOC_BYPASS_EN lets an allocating operand capture a same-cycle CDB broadcast.
module rs_issue_sched
    import tomasulo_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = RS_TAG_W,
    parameter int DATA_W = RS_DATA_W,
    parameter int FUNC_W = RS_FUNC_W
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [FUNC_W-1:0]        alloc_func,
    input  logic                     alloc_rs1_b,
    input  logic [DATA_W-1:0]        alloc_rs1,
    input  logic                     alloc_rs2_b,
    input  logic [DATA_W-1:0]        alloc_rs2,
    input  logic [TAG_W-1:0]         alloc_rob,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [DATA_W-1:0]        cdb_data,
    output logic                     disp_valid,
    input  logic                     disp_ready,
    output logic [FUNC_W-1:0]        disp_func,
    output logic [DATA_W-1:0]        disp_op1,
    output logic [DATA_W-1:0]        disp_op2,
    output logic [TAG_W-1:0]         disp_rob,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    rs_entry_t         r_ent [DEPTH];
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_disp_idx;
    logic              r_disp_valid;
    logic [FUNC_W-1:0] r_disp_func;
    logic [DATA_W-1:0] r_disp_op1;
    logic [DATA_W-1:0] r_disp_op2;
    logic [TAG_W-1:0]  r_disp_rob;

    logic [CNT_W-1:0]  w_occ;
    logic              w_alloc_fire;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_xfer;
    logic              w_sel_en;
    logic [DEPTH-1:0]  w_req;
    logic [DEPTH-1:0]  w_grant;
    logic              w_gnt_any;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic [IDX_W-1:0]  w_arb_ptr;
    logic              w_byp1;
    logic              w_byp2;
    rs_entry_t         w_new;

    always_comb begin
        w_occ      = '0;
        w_free_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + CNT_W'(r_ent[i].busy);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_ent[i].busy) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign alloc_ready  = (w_occ < CNT_W'(DEPTH));
    assign w_alloc_fire = alloc_valid & alloc_ready;
    assign w_xfer       = r_disp_valid & disp_ready;
    assign w_sel_en     = !r_disp_valid | disp_ready;
    assign w_arb_ptr    = w_xfer ? (r_disp_idx + IDX_W'(1)) : r_rr_ptr;

`ifdef RS_ALLOC_BYPASS_EN
    assign w_byp1 = cdb_valid && !alloc_rs1_b && (alloc_rs1[TAG_W-1:0] == cdb_tag);
    assign w_byp2 = cdb_valid && !alloc_rs2_b && (alloc_rs2[TAG_W-1:0] == cdb_tag);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    always_comb begin
        w_new        = '0;
        w_new.busy   = 1'b1;
        w_new.func   = alloc_func;
        w_new.q1_rdy = alloc_rs1_b | w_byp1;
        w_new.v1     = w_byp1 ? cdb_data : alloc_rs1;
        w_new.q2_rdy = alloc_rs2_b | w_byp2;
        w_new.v2     = w_byp2 ? cdb_data : alloc_rs2;
        w_new.rob    = alloc_rob;
    end

    // The entry already sitting in the output stage must not be picked a second time.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_req[i] = r_ent[i].busy & r_ent[i].q1_rdy & r_ent[i].q2_rdy &
                       !(r_disp_valid && (r_disp_idx == IDX_W'(i)));
        end
    end

    rr_arbiter #(
        .DEPTH (DEPTH)
    ) u_rr_arbiter (
        .i_req   (w_req),
        .i_ptr   (w_arb_ptr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_gnt_idx = IDX_W'(i);
            end
        end
    end

    assign w_gnt_any = |w_grant;

    // Allocation only targets free entries, so it never collides with dispatch or wakeup.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_fire && (w_free_idx == IDX_W'(i))) begin
                    r_ent[i] <= w_new;
                end else if (w_xfer && (r_disp_idx == IDX_W'(i))) begin
                    r_ent[i].busy <= 1'b0;
                end else if (r_ent[i].busy && cdb_valid) begin
                    if (!r_ent[i].q1_rdy && (r_ent[i].v1[TAG_W-1:0] == cdb_tag)) begin
                        r_ent[i].q1_rdy <= 1'b1;
                        r_ent[i].v1     <= cdb_data;
                    end
                    if (!r_ent[i].q2_rdy && (r_ent[i].v2[TAG_W-1:0] == cdb_tag)) begin
                        r_ent[i].q2_rdy <= 1'b1;
                        r_ent[i].v2     <= cdb_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_valid <= 1'b0;
            r_disp_idx   <= '0;
            r_disp_func  <= '0;
            r_disp_op1   <= '0;
            r_disp_op2   <= '0;
            r_disp_rob   <= '0;
            r_rr_ptr     <= '0;
        end else if (flush) begin
            r_disp_valid <= 1'b0;
            r_disp_idx   <= '0;
            r_disp_func  <= '0;
            r_disp_op1   <= '0;
            r_disp_op2   <= '0;
            r_disp_rob   <= '0;
            r_rr_ptr     <= '0;
        end else begin
            if (w_xfer) begin
                r_rr_ptr <= r_disp_idx + IDX_W'(1);
            end
            if (w_sel_en) begin
                r_disp_valid <= w_gnt_any;
                if (w_gnt_any) begin
                    r_disp_idx  <= w_gnt_idx;
                    r_disp_func <= r_ent[w_gnt_idx].func;
                    r_disp_op1  <= r_ent[w_gnt_idx].v1;
                    r_disp_op2  <= r_ent[w_gnt_idx].v2;
                    r_disp_rob  <= r_ent[w_gnt_idx].rob;
                end
            end
        end
    end

    assign disp_valid = r_disp_valid;
    assign disp_func  = r_disp_func;
    assign disp_op1   = r_disp_op1;
    assign disp_op2   = r_disp_op2;
    assign disp_rob   = r_disp_rob;
    assign occupancy  = w_occ;

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed scoreboard bench for rs_issue_sched: expected dispatches are queued at issue and
// checked by an independent monitor whenever a dispatch handshake completes.
module tb_rs_issue_sched;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_func;
    logic        alloc_rs1_b;
    logic [15:0] alloc_rs1;
    logic        alloc_rs2_b;
    logic [15:0] alloc_rs2;
    logic [2:0]  alloc_rob;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        disp_valid;
    logic        disp_ready;
    logic [3:0]  disp_func;
    logic [15:0] disp_op1;
    logic [15:0] disp_op2;
    logic [2:0]  disp_rob;
    logic [2:0]  occupancy;

    logic [38:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    rs_issue_sched #(
        .DEPTH  (4),
        .TAG_W  (3),
        .DATA_W (16),
        .FUNC_W (4)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_func  (alloc_func),
        .alloc_rs1_b (alloc_rs1_b),
        .alloc_rs1   (alloc_rs1),
        .alloc_rs2_b (alloc_rs2_b),
        .alloc_rs2   (alloc_rs2),
        .alloc_rob   (alloc_rob),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_func   (disp_func),
        .disp_op1    (disp_op1),
        .disp_op2    (disp_op2),
        .disp_rob    (disp_rob),
        .occupancy   (occupancy)
    );

    // clock / reset
    always #5 clk1 = ~clk1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [38:0] pack(input logic [3:0] f, input logic [15:0] a,
                                         input logic [15:0] b, input logic [2:0] r);
        return {f, a, b, r};
    endfunction

    // monitor: a completed handshake must match the head of the expected queue
    always @(negedge clk1) begin
        if (rst_n && disp_valid && disp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_dispatch: got %0h expected none",
                         {disp_func, disp_op1, disp_op2, disp_rob});
            end else begin
                chk("dispatch", 64'({disp_func, disp_op1, disp_op2, disp_rob}), 64'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_alloc(input logic [3:0] f, input logic b1, input logic [15:0] a1,
                            input logic b2, input logic [15:0] a2, input logic [2:0] rob);
        alloc_valid = 1'b1;
        alloc_func  = f;
        alloc_rs1_b = b1;
        alloc_rs1   = a1;
        alloc_rs2_b = b2;
        alloc_rs2   = a2;
        alloc_rob   = rob;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [2:0] tag, input logic [15:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || occupancy != 3'd0) && n < max_cycles) begin
            tick();
            n++;
        end
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_occupancy"}, 64'(occupancy), 64'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        alloc_valid = 1'b0;
        alloc_func  = '0;
        alloc_rs1_b = 1'b0;
        alloc_rs1   = '0;
        alloc_rs2_b = 1'b0;
        alloc_rs2   = '0;
        alloc_rob   = '0;
        cdb_valid   = 1'b0;
        cdb_tag     = '0;
        cdb_data    = '0;
        disp_ready  = 1'b0;

        // reset state
        #12;
        chk("reset_disp_valid", 64'(disp_valid), 64'd0);
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_disp_fields", 64'({disp_func, disp_op1, disp_op2, disp_rob}), 64'd0);
        @(negedge clk1);
        rst_n = 1'b1;
        tick();
        chk("reset_alloc_ready", 64'(alloc_ready), 64'd1);

        // both operands ready: ADD 5,7 -> rob 3
        disp_ready = 1'b1;
        exp_q.push_back(pack(4'b0000, 16'd5, 16'd7, 3'd3));
        do_alloc(4'b0000, 1'b1, 16'd5, 1'b1, 16'd7, 3'd3);
        chk("t1_occupancy_after_alloc", 64'(occupancy), 64'd1);
        wait_drain("t1", 10);

        // rs1 waits on tag 2, woken by CDB two cycles later
        exp_q.push_back(pack(4'b0001, 16'h00AA, 16'd9, 3'd1));
        do_alloc(4'b0001, 1'b0, 16'd2, 1'b1, 16'd9, 3'd1);
        tick();
        tick();
        chk("t2_pending_no_dispatch", 64'(disp_valid), 64'd0);
        do_cdb(3'd2, 16'h00AA);
        chk("t2_not_yet_presented", 64'(disp_valid), 64'd0);
        tick();
        chk("t2_presented", 64'(disp_valid), 64'd1);
        wait_drain("t2", 10);

        // fill all four entries while stalled, then release in rr order
        disp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pack(4'b0010, 16'(i), 16'(i + 10), 3'(i)));
            do_alloc(4'b0010, 1'b1, 16'(i), 1'b1, 16'(i + 10), 3'(i));
        end
        chk("t3_full_alloc_ready", 64'(alloc_ready), 64'd0);
        chk("t3_full_occupancy", 64'(occupancy), 64'd4);
        do_alloc(4'b0011, 1'b1, 16'hDEAD, 1'b1, 16'hBEEF, 3'd5);
        chk("t3_ignored_alloc_occupancy", 64'(occupancy), 64'd4);
        disp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_back_to_back_valid", 64'(disp_valid), 64'd1);
            tick();
        end
        wait_drain("t3", 10);

        // stall for three cycles while a second entry wakes up behind the presented one
        disp_ready = 1'b0;
        exp_q.push_back(pack(4'b0000, 16'h0011, 16'h0022, 3'd2));
        exp_q.push_back(pack(4'b0110, 16'h0033, 16'h0005, 3'd4));
        do_alloc(4'b0000, 1'b1, 16'h0011, 1'b1, 16'h0022, 3'd2);
        do_alloc(4'b0110, 1'b0, 16'd6, 1'b1, 16'h0005, 3'd4);
        tick();
        do_cdb(3'd6, 16'h0033);
        for (int i = 0; i < 3; i++) begin
            chk("t4_stall_valid", 64'(disp_valid), 64'd1);
            chk("t4_stall_fields", 64'({disp_func, disp_op1, disp_op2, disp_rob}),
                64'(pack(4'b0000, 16'h0011, 16'h0022, 3'd2)));
            tick();
        end
        disp_ready = 1'b1;
        wait_drain("t4", 10);

        // flush with three entries busy and a same-cycle alloc
        disp_ready = 1'b0;
        do_alloc(4'b0000, 1'b1, 16'd1, 1'b1, 16'd2, 3'd0);
        do_alloc(4'b0001, 1'b0, 16'd7, 1'b1, 16'd3, 3'd1);
        do_alloc(4'b0001, 1'b1, 16'd4, 1'b0, 16'd7, 3'd2);
        chk("t5_pre_flush_valid", 64'(disp_valid), 64'd1);
        chk("t5_pre_flush_occupancy", 64'(occupancy), 64'd3);
        flush = 1'b1;
        do_alloc(4'b0000, 1'b1, 16'd8, 1'b1, 16'd9, 3'd3);
        flush = 1'b0;
        chk("t5_flush_occupancy", 64'(occupancy), 64'd0);
        chk("t5_flush_valid", 64'(disp_valid), 64'd0);
        chk("t5_flush_alloc_ready", 64'(alloc_ready), 64'd1);
        disp_ready = 1'b1;
        do_cdb(3'd7, 16'h0070);
        for (int i = 0; i < 4; i++) tick();
        chk("t5_post_flush_occupancy", 64'(occupancy), 64'd0);

        // both operands of one entry wake on the same broadcast
        exp_q.push_back(pack(4'b0010, 16'h0077, 16'h0077, 3'd5));
        do_alloc(4'b0010, 1'b0, 16'd5, 1'b0, 16'd5, 3'd5);
        tick();
        do_cdb(3'd5, 16'h0077);
        wait_drain("t6", 10);

        // allocation against a tag being broadcast in the same cycle
        cdb_valid = 1'b1;
        cdb_tag   = 3'd4;
        cdb_data  = 16'h0044;
`ifdef RS_ALLOC_BYPASS_EN
        exp_q.push_back(pack(4'b0111, 16'h0044, 16'h0001, 3'd6));
        do_alloc(4'b0111, 1'b0, 16'd4, 1'b1, 16'h0001, 3'd6);
        cdb_valid = 1'b0;
        wait_drain("t7_bypass", 10);
`else
        do_alloc(4'b0111, 1'b0, 16'd4, 1'b1, 16'h0001, 3'd6);
        cdb_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t7_missed_pending_occ", 64'(occupancy), 64'd1);
        chk("t7_missed_pending_valid", 64'(disp_valid), 64'd0);
        exp_q.push_back(pack(4'b0111, 16'h0055, 16'h0001, 3'd6));
        do_cdb(3'd4, 16'h0055);
        wait_drain("t7_late_wakeup", 10);
`endif

        // asynchronous reset while a dispatch is presented
        disp_ready = 1'b0;
        do_alloc(4'b0001, 1'b1, 16'd3, 1'b1, 16'd4, 3'd7);
        tick();
        chk("t8_presented", 64'(disp_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t8_async_valid", 64'(disp_valid), 64'd0);
        chk("t8_async_occupancy", 64'(occupancy), 64'd0);
        chk("t8_async_fields", 64'({disp_func, disp_op1, disp_op2, disp_rob}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t8_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        // report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
